load_store_queue: RTL
=====================

Name: load_store_queue

Overview:
- Parametrised in-order load/store queue; successor to the fixed-size LSU.
- Sits between issue logic, the CDB and data memory.
- Allocates entries in program order and captures operand tags/values from the CDB.
- Issues ready non-speculative entries oldest-first to dmem, broadcasts load results through a CDB request/grant handshake, and squashes speculative entries on branch mispredict.

Parameters:
- DEPTH_POW2, 3, queue depth = 2**DEPTH_POW2 entries.
- XLEN, 32, address/data width.
- TAG_W, 5, tag width; tag value 0 = NO_VAL (operand present).
- TAG_BASE, 16, entry i owns tag TAG_BASE+i; fixed for the life of the entry slot.

Ports:
- clk_i  in  1  clock
- reset_i  in  1  reset; synchronous, active-high
- alloc_valid_i  in  1  allocation request
- alloc_ready_o  out  1  queue not full
- alloc_load_i  in  1  1=load, 0=store
- alloc_addr_tag_i  in  TAG_W  base-address tag (0=value valid)
- alloc_addr_i  in  XLEN  base address
- alloc_offset_i  in  XLEN  immediate offset
- alloc_data_tag_i  in  TAG_W  store-data tag (0=value valid)
- alloc_data_i  in  XLEN  store data
- alloc_spec_i  in  1  instruction is under an unresolved branch
- alloc_tag_o  out  TAG_W  tag of slot at head (tag given to next allocation)
- cdb_tag_i  in  TAG_W  CDB broadcast tag
- cdb_val_i  in  XLEN  CDB broadcast value
- br_resolve_i  in  1  branch resolved this cycle
- br_mispred_i  in  1  resolved branch was mispredicted (qualified by br_resolve_i)
- cdb_req_o  out  1  load result pending broadcast
- cdb_tag_o  out  TAG_W  load result tag
- cdb_val_o  out  XLEN  load result value
- cdb_gnt_i  in  1  CDB arbiter grant
- dmem_req_o  out  1  memory request
- dmem_we_o  out  1  1=write
- dmem_addr_o  out  XLEN  effective address
- dmem_wdata_o  out  XLEN  store data
- dmem_rdata_i  in  XLEN  load data
- dmem_done_i  in  1  request complete
- count_o  out  DEPTH_POW2+1  occupied entries

Behaviour:
- Storage and pointers:
  - Circular buffer with head (alloc), tail (oldest) and count.
  - Pointers wrap mod 2**DEPTH_POW2.
  - alloc_ready_o = (count != DEPTH); it depends on registered count only, so a retire in the same cycle does not free a slot that cycle.
- Reset:
  - head=tail=0, count=0, all valid/spec bits 0, FSM=IDLE.
  - All outputs 0 except alloc_tag_o=TAG_BASE and alloc_ready_o=1.
- Allocation (alloc_valid_i & alloc_ready_o):
  - Writes all fields at head, sets valid, head++.
  - If a field tag is nonzero and equals cdb_tag_i in the same cycle, the entry stores tag 0 and value cdb_val_i (same-cycle bypass).
- Wakeup: each valid entry with nonzero addr/data tag equal to cdb_tag_i clears that tag and captures cdb_val_i.
- Speculation (single level):
  - Issue logic guarantees speculative entries are the youngest contiguous run.
  - br_resolve_i & ~br_mispred_i: clear spec on all entries.
  - br_resolve_i & br_mispred_i: invalidate all spec entries; head moves back to the oldest spec slot; count is reduced accordingly.
  - In a mispredict cycle, a spec allocation is dropped; a non-spec allocation lands at the post-squash head.
  - Resolve with no spec entries: no effect.
- Ready: the tail entry is valid & ~spec & addr_tag==0 & (load | data_tag==0).
- Effective address: addr + offset, truncated to XLEN (wraps).
- FSM:
  - IDLE: if tail ready, latch eff addr, data and we, then go to MEM. dmem_req_o rises the cycle after ready is first seen.
  - MEM: dmem_req_o=1; addr/we/wdata stable until dmem_done_i. On done:
    - store: retire tail (tail++, count--), go to IDLE.
    - load: latch dmem_rdata_i, go to BCAST.
  - BCAST: cdb_req_o=1, cdb_tag_o=TAG_BASE+tail, cdb_val_o=latched data; values held until cdb_gnt_i. On grant, retire tail and go to IDLE. A load retires only on grant, so its tag is never reused while pending.
- Timing:
  - Store latency: ready to retire = 2 cycles, with done returned in the first request cycle.
  - Load latency: ready to cdb_req_o = 2 cycles.
- Entries in MEM/BCAST are never spec, so a mispredict never affects an in-flight op.
- Simultaneous allocate + retire: both apply; count unchanged.
- Reset mid-operation: FSM returns to IDLE and dmem_req_o drops the next cycle; the memory side must tolerate an abandoned request.

Optional Feature:
- Macro: LSQ_SUBWORD_EN.
- When defined, adds ports:
  - alloc_size_i in 2 (00=byte, 01=half, 10=word)
  - alloc_unsigned_i in 1
  - dmem_be_o out XLEN/8
- Stores: dmem_be_o is selected by eff_addr low bits; wdata is replicated into lanes.
- Loads: the lane is extracted and sign- or zero-extended before broadcast.
- Misaligned accesses are silently aligned down.
- Undefined: ports absent, word accesses only, low address bits passed through.

Test Plan:
- Reset, then alloc store addr_tag=0 addr=0x100 off=4 data=0xDEAD, done after 1 cycle -> dmem_we_o=1, addr 0x104, wdata 0xDEAD; count 1->0.
- Alloc load addr_tag=7; CDB tag 7 val 0x200; dmem_rdata=0x55 -> dmem_addr 0x200+off; cdb_req_o tag=TAG_BASE+slot, val 0x55, held 3 cycles until cdb_gnt_i.
- Fill 8 entries with unready tags -> alloc_ready_o=0; allocating while full is ignored. Wake and drain all; pointers wrap and the 9th alloc receives tag TAG_BASE+0.
- 2 non-spec + 3 spec entries, then mispredict -> count 5->2, head back to slot 2. Correct-predict variant: spec bits clear and the 3 entries issue in order.
- Same-cycle alloc with addr_tag=9 and CDB tag 9 val 0x40 -> entry is ready the next cycle with addr 0x40.
- LSQ_SUBWORD_EN: signed byte load at 0x103, rdata 0x80xxxxxx -> cdb_val 0xFFFFFF80; byte store at 0x101 -> dmem_be_o=4'b0010.

Source files
------------

// File: rtl/load_store_queue_if.sv
// lsq_if: issue/CDB/branch/dmem bundle for load_store_queue.
// The slave modport is the queue side, master is the surrounding core and memory.
// LSQ_SUBWORD_EN adds size/sign-mode on allocation and byte enables toward dmem.
interface lsq_if #(
  parameter int DEPTH_POW2 = 3,
  parameter int XLEN       = 32,
  parameter int TAG_W      = 5
);
  logic                  alloc_valid_i;
  logic                  alloc_ready_o;
  logic                  alloc_load_i;
  logic [TAG_W-1:0]      alloc_addr_tag_i;
  logic [XLEN-1:0]       alloc_addr_i;
  logic [XLEN-1:0]       alloc_offset_i;
  logic [TAG_W-1:0]      alloc_data_tag_i;
  logic [XLEN-1:0]       alloc_data_i;
  logic                  alloc_spec_i;
  logic [TAG_W-1:0]      alloc_tag_o;
  logic [TAG_W-1:0]      cdb_tag_i;
  logic [XLEN-1:0]       cdb_val_i;
  logic                  br_resolve_i;
  logic                  br_mispred_i;
  logic                  cdb_req_o;
  logic [TAG_W-1:0]      cdb_tag_o;
  logic [XLEN-1:0]       cdb_val_o;
  logic                  cdb_gnt_i;
  logic                  dmem_req_o;
  logic                  dmem_we_o;
  logic [XLEN-1:0]       dmem_addr_o;
  logic [XLEN-1:0]       dmem_wdata_o;
  logic [XLEN-1:0]       dmem_rdata_i;
  logic                  dmem_done_i;
  logic [DEPTH_POW2:0]   count_o;
`ifdef LSQ_SUBWORD_EN
  logic [1:0]            alloc_size_i;
  logic                  alloc_unsigned_i;
  logic [XLEN/8-1:0]     dmem_be_o;
`endif

  modport slave (
`ifdef LSQ_SUBWORD_EN
    input  alloc_size_i, alloc_unsigned_i,
    output dmem_be_o,
`endif
    input  alloc_valid_i, alloc_load_i, alloc_addr_tag_i, alloc_addr_i, alloc_offset_i,
           alloc_data_tag_i, alloc_data_i, alloc_spec_i, cdb_tag_i, cdb_val_i,
           br_resolve_i, br_mispred_i, cdb_gnt_i, dmem_rdata_i, dmem_done_i,
    output alloc_ready_o, alloc_tag_o, cdb_req_o, cdb_tag_o, cdb_val_o,
           dmem_req_o, dmem_we_o, dmem_addr_o, dmem_wdata_o, count_o
  );

  modport master (
`ifdef LSQ_SUBWORD_EN
    output alloc_size_i, alloc_unsigned_i,
    input  dmem_be_o,
`endif
    output alloc_valid_i, alloc_load_i, alloc_addr_tag_i, alloc_addr_i, alloc_offset_i,
           alloc_data_tag_i, alloc_data_i, alloc_spec_i, cdb_tag_i, cdb_val_i,
           br_resolve_i, br_mispred_i, cdb_gnt_i, dmem_rdata_i, dmem_done_i,
    input  alloc_ready_o, alloc_tag_o, cdb_req_o, cdb_tag_o, cdb_val_o,
           dmem_req_o, dmem_we_o, dmem_addr_o, dmem_wdata_o, count_o
  );
endinterface

// File: rtl/load_store_queue.sv
// load_store_queue: in-order circular LSQ. Entries capture operands off the CDB,
// the oldest ready non-speculative entry goes to dmem, load results return via
// a CDB request/grant handshake, and a mispredict squashes the speculative tail run.
// Optional macro LSQ_SUBWORD_EN: byte/half accesses with byte enables and load extension.
module load_store_queue #(
  parameter int DEPTH_POW2 = 3,
  parameter int XLEN       = 32,
  parameter int TAG_W      = 5,
  parameter int TAG_BASE   = 16
) (
  input logic clk_i,
  input logic reset_i,
  lsq_if.slave bus
);
  localparam int DEPTH = 1 << DEPTH_POW2;
  localparam int CNT_W = DEPTH_POW2 + 1;
  typedef logic [DEPTH_POW2-1:0] ptr_t;

  typedef struct packed {
    logic             load;
    logic             spec;
    logic [TAG_W-1:0] addr_tag;
    logic [TAG_W-1:0] data_tag;
    logic [XLEN-1:0]  addr;
    logic [XLEN-1:0]  offset;
    logic [XLEN-1:0]  data;
`ifdef LSQ_SUBWORD_EN
    logic [1:0]       size;
    logic             is_unsigned;
`endif
  } entry_t;

  typedef enum logic [1:0] {IDLE, MEM, BCAST} state_t;

  entry_t           ent_q [DEPTH];
  logic [DEPTH-1:0] valid_q;
  ptr_t             head_q, tail_q;
  logic [CNT_W-1:0] count_q;
  state_t           state_q;
  logic             dmem_req_q, dmem_we_q, cdb_req_q;
  logic [XLEN-1:0]  dmem_addr_q, dmem_wdata_q, cdb_val_q;
  logic [TAG_W-1:0] cdb_tag_q;

`ifdef LSQ_SUBWORD_EN
  localparam int NB    = XLEN / 8;
  localparam int OFF_W = $clog2(NB);
  logic [NB-1:0]    dmem_be_q;
  logic [OFF_W-1:0] ld_off_q;
  logic [1:0]       ld_size_q;
  logic             ld_uns_q;

  function automatic int nbytes(input logic [1:0] sz);
    case (sz)
      2'b00:   return 1;
      2'b01:   return 2;
      default: return NB;
    endcase
  endfunction

  // Lane offset aligned down to the access size.
  function automatic logic [OFF_W-1:0] lane_off(input logic [XLEN-1:0] a, input logic [1:0] sz);
    return a[OFF_W-1:0] & ~OFF_W'(nbytes(sz) - 1);
  endfunction

  function automatic logic [NB-1:0] be_mask(input logic [XLEN-1:0] a, input logic [1:0] sz);
    logic [NB-1:0] m;
    m = {NB{1'b1}} >> (NB - nbytes(sz));
    return m << lane_off(a, sz);
  endfunction

  function automatic logic [XLEN-1:0] rep_data(input logic [XLEN-1:0] d, input logic [1:0] sz);
    logic [XLEN-1:0] r;
    r = '0;
    for (int b = 0; b < NB; b++) r[b*8 +: 8] = d[(b % nbytes(sz))*8 +: 8];
    return r;
  endfunction

  function automatic logic [XLEN-1:0] ld_ext(input logic [XLEN-1:0] rd, input logic [OFF_W-1:0] off,
                                             input logic [1:0] sz, input logic uns);
    logic [XLEN-1:0] s;
    s = rd >> {off, 3'b000};
    case (sz)
      2'b00:   return uns ? XLEN'(s[7:0])  : {{(XLEN-8){s[7]}}, s[7:0]};
      2'b01:   return uns ? XLEN'(s[15:0]) : {{(XLEN-16){s[15]}}, s[15:0]};
      default: return s;
    endcase
  endfunction
`endif

  logic             squash, commit, alloc_fire, retire, tail_ready;
  logic [CNT_W-1:0] spec_cnt;
  ptr_t             head_sq;
  entry_t           tail_ent, new_ent;
  logic [XLEN-1:0]  eff_addr;

  assign squash     = bus.br_resolve_i & bus.br_mispred_i;
  assign commit     = bus.br_resolve_i & ~bus.br_mispred_i;
  assign alloc_fire = bus.alloc_valid_i & bus.alloc_ready_o & ~(squash & bus.alloc_spec_i);
  // A store retires on done; a load only once its broadcast is granted.
  assign retire     = (state_q == MEM && bus.dmem_done_i && dmem_we_q) ||
                      (state_q == BCAST && bus.cdb_gnt_i);
  assign tail_ent   = ent_q[tail_q];
  assign tail_ready = valid_q[tail_q] & ~tail_ent.spec & (tail_ent.addr_tag == '0) &
                      (tail_ent.load | (tail_ent.data_tag == '0));
  assign eff_addr   = tail_ent.addr + tail_ent.offset;
  // Spec entries are the youngest contiguous run, so squash just rewinds head by their count.
  // A full-queue squash truncates spec_cnt to 0, which is the correct full wrap.
  assign head_sq    = squash ? head_q - ptr_t'(spec_cnt) : head_q;

  // Count live speculative entries.
  always_comb begin
    spec_cnt = '0;
    for (int i = 0; i < DEPTH; i++) spec_cnt = spec_cnt + CNT_W'(valid_q[i] & ent_q[i].spec);
  end

  // New entry, with same-cycle CDB bypass on either operand tag.
  always_comb begin
    new_ent          = '0;
    new_ent.load     = bus.alloc_load_i;
    new_ent.spec     = bus.alloc_spec_i & ~commit;
    new_ent.addr_tag = bus.alloc_addr_tag_i;
    new_ent.addr     = bus.alloc_addr_i;
    new_ent.data_tag = bus.alloc_data_tag_i;
    new_ent.data     = bus.alloc_data_i;
    new_ent.offset   = bus.alloc_offset_i;
    if (bus.alloc_addr_tag_i != '0 && bus.alloc_addr_tag_i == bus.cdb_tag_i) begin
      new_ent.addr_tag = '0;
      new_ent.addr     = bus.cdb_val_i;
    end
    if (bus.alloc_data_tag_i != '0 && bus.alloc_data_tag_i == bus.cdb_tag_i) begin
      new_ent.data_tag = '0;
      new_ent.data     = bus.cdb_val_i;
    end
`ifdef LSQ_SUBWORD_EN
    new_ent.size        = bus.alloc_size_i;
    new_ent.is_unsigned = bus.alloc_unsigned_i;
`endif
  end

  // Queue storage: wakeup, speculation resolve, allocate, retire, pointers.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      for (int i = 0; i < DEPTH; i++) ent_q[i] <= '0;
      valid_q <= '0;
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (valid_q[i] && ent_q[i].addr_tag != '0 && ent_q[i].addr_tag == bus.cdb_tag_i) begin
          ent_q[i].addr_tag <= '0;
          ent_q[i].addr     <= bus.cdb_val_i;
        end
        if (valid_q[i] && ent_q[i].data_tag != '0 && ent_q[i].data_tag == bus.cdb_tag_i) begin
          ent_q[i].data_tag <= '0;
          ent_q[i].data     <= bus.cdb_val_i;
        end
        if (commit) ent_q[i].spec <= 1'b0;
        if (squash && ent_q[i].spec) valid_q[i] <= 1'b0;
      end
      if (retire) valid_q[tail_q] <= 1'b0;
      // Placed last so an allocation into a just-squashed slot wins.
      if (alloc_fire) begin
        ent_q[head_sq]   <= new_ent;
        valid_q[head_sq] <= 1'b1;
      end
      head_q  <= head_sq + ptr_t'(alloc_fire);
      if (retire) tail_q <= tail_q + 1'b1;
      count_q <= count_q - (squash ? spec_cnt : '0) + CNT_W'(alloc_fire) - CNT_W'(retire);
    end
  end

  // Issue FSM: IDLE latches the tail op, MEM waits for done, BCAST waits for grant.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q      <= IDLE;
      dmem_req_q   <= 1'b0;
      dmem_we_q    <= 1'b0;
      dmem_addr_q  <= '0;
      dmem_wdata_q <= '0;
      cdb_req_q    <= 1'b0;
      cdb_tag_q    <= '0;
      cdb_val_q    <= '0;
`ifdef LSQ_SUBWORD_EN
      dmem_be_q    <= '0;
      ld_off_q     <= '0;
      ld_size_q    <= '0;
      ld_uns_q     <= 1'b0;
`endif
    end else begin
      case (state_q)
        IDLE: if (tail_ready) begin
          state_q    <= MEM;
          dmem_req_q <= 1'b1;
          dmem_we_q  <= ~tail_ent.load;
`ifdef LSQ_SUBWORD_EN
          dmem_addr_q  <= eff_addr & ~XLEN'(NB - 1);
          dmem_wdata_q <= rep_data(tail_ent.data, tail_ent.size);
          dmem_be_q    <= be_mask(eff_addr, tail_ent.size);
          ld_off_q     <= lane_off(eff_addr, tail_ent.size);
          ld_size_q    <= tail_ent.size;
          ld_uns_q     <= tail_ent.is_unsigned;
`else
          dmem_addr_q  <= eff_addr;
          dmem_wdata_q <= tail_ent.data;
`endif
        end
        MEM: if (bus.dmem_done_i) begin
          dmem_req_q <= 1'b0;
          if (dmem_we_q) begin
            state_q <= IDLE;
          end else begin
            state_q   <= BCAST;
            cdb_req_q <= 1'b1;
            cdb_tag_q <= TAG_W'(TAG_BASE) + TAG_W'(tail_q);
`ifdef LSQ_SUBWORD_EN
            cdb_val_q <= ld_ext(bus.dmem_rdata_i, ld_off_q, ld_size_q, ld_uns_q);
`else
            cdb_val_q <= bus.dmem_rdata_i;
`endif
          end
        end
        BCAST: if (bus.cdb_gnt_i) begin
          cdb_req_q <= 1'b0;
          state_q   <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.alloc_ready_o = (count_q != CNT_W'(DEPTH));
  assign bus.alloc_tag_o   = TAG_W'(TAG_BASE) + TAG_W'(head_q);
  assign bus.count_o       = count_q;
  assign bus.dmem_req_o    = dmem_req_q;
  assign bus.dmem_we_o     = dmem_we_q;
  assign bus.dmem_addr_o   = dmem_addr_q;
  assign bus.dmem_wdata_o  = dmem_wdata_q;
  assign bus.cdb_req_o     = cdb_req_q;
  assign bus.cdb_tag_o     = cdb_tag_q;
  assign bus.cdb_val_o     = cdb_val_q;
`ifdef LSQ_SUBWORD_EN
  assign bus.dmem_be_o     = dmem_be_q;
`endif
endmodule
